// File: rtl/ov7670_pixel_capture.sv
`timescale 1ns/1ps
// ov7670_pixel_capture
//  Write-side capture of the OV7670 byte stream into a linear frame buffer.
//  Each RGB565 byte pair is packed into one RGB444 word and written at
//  consecutive addresses 0..H_RES*V_RES-1, starting after the first vsync fall
//  seen since reset.
//
//  Ports
//    PCLK       camera pixel clock (only clock)
//    rst        synchronous active-high reset
//    vsync      camera vsync, high = vertical blanking
//    href       camera href, high = valid bytes on d
//    d[7:0]     camera data byte
//    test_mode  select colour-bar test pattern (CAPTURE_TEST_PATTERN_EN builds only)
//    addr       frame-buffer write address
//    dout[11:0] pixel {R[3:0],G[3:0],B[3:0]}
//    we         one-cycle write strobe per pixel
//    overflow   sticky: frame delivered more than H_RES*V_RES pixels
//
//  Optional feature macro: CAPTURE_TEST_PATTERN_EN
//    defined   : test_mode=1 replaces dout with 8 vertical colour bars
//    undefined : test_mode is ignored, no column counter is built
module ov7670_pixel_capture #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              PCLK,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              test_mode,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              we,
  output logic              overflow
);

  localparam int                FRAME_PIXELS = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FRAME_END    = ADDR_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    IDLE,
    CAPTURE
  } state_t;

  state_t state_reg, state_next;

  // Input stage plus one extra tap for edge detection.
  logic       vsync_s1_reg, href_s1_reg;
  logic [7:0] d_s1_reg;
  logic       vsync_prev_reg, href_prev_reg;

  logic [6:0]        hi_reg;          // {R5[4:1], G6[5:3]} of the first byte
  logic              byte_phase_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [11:0]       dout_reg;
  logic              we_reg;
  logic              overflow_reg;

  logic        vsync_fall, href_rise, href_fall;
  logic        take_byte, phase_now, pixel_done, frame_full;
  logic [11:0] camera_word, pixel_word;

  always_ff @(posedge PCLK) begin
    if (rst) begin
      vsync_s1_reg   <= 1'b0;
      href_s1_reg    <= 1'b0;
      d_s1_reg       <= 8'h00;
      vsync_prev_reg <= 1'b0;
      href_prev_reg  <= 1'b0;
    end else begin
      vsync_s1_reg   <= vsync;
      href_s1_reg    <= href;
      d_s1_reg       <= d;
      vsync_prev_reg <= vsync_s1_reg;
      href_prev_reg  <= href_s1_reg;
    end
  end

  assign vsync_fall = vsync_prev_reg & ~vsync_s1_reg;
  assign href_rise  = href_s1_reg & ~href_prev_reg;
  assign href_fall  = href_prev_reg & ~href_s1_reg;

  always_ff @(posedge PCLK) begin
    if (rst) state_reg <= WAIT_FRAME;
    else     state_reg <= state_next;
  end

  // take_byte marks a camera byte that belongs to the frame being written.
  // The byte arriving with href rise is always the first byte of a pair.
  always_comb begin
    state_next = state_reg;
    take_byte  = 1'b0;
    phase_now  = href_rise ? 1'b0 : byte_phase_reg;
    if (vsync_fall) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        WAIT_FRAME: state_next = WAIT_FRAME;
        IDLE: begin
          if (href_rise) begin
            state_next = CAPTURE;
            take_byte  = ~vsync_s1_reg;
          end
        end
        CAPTURE: begin
          if (href_fall) state_next = IDLE;
          else           take_byte  = href_s1_reg & ~vsync_s1_reg;
        end
        default: state_next = WAIT_FRAME;
      endcase
    end
  end

  assign pixel_done  = take_byte & phase_now;
  assign frame_full  = (addr_reg == FRAME_END);
  assign camera_word = {hi_reg[6:3], hi_reg[2:0], d_s1_reg[7], d_s1_reg[4:1]};

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam int COL_W = $clog2(H_RES) + 1;
  localparam int BAR_W = (H_RES >= 8) ? (H_RES / 8) : 1;

  logic [COL_W-1:0] col_reg;
  logic [COL_W-1:0] bar_full;
  logic [2:0]       bar;
  logic [11:0]      bar_colour;

  // Column of the next pixel in the current line; saturates on over-long lines.
  always_ff @(posedge PCLK) begin
    if (rst)                                 col_reg <= '0;
    else if (href_rise)                      col_reg <= '0;
    else if (pixel_done && (col_reg != '1))  col_reg <= col_reg + COL_W'(1);
  end

  assign bar_full = col_reg / COL_W'(BAR_W);
  assign bar      = (bar_full > COL_W'(7)) ? 3'd7 : bar_full[2:0];

  always_comb begin
    bar_colour = 12'h000;
    case (bar)
      3'd0: bar_colour = 12'hFFF;
      3'd1: bar_colour = 12'hFF0;
      3'd2: bar_colour = 12'h0FF;
      3'd3: bar_colour = 12'h0F0;
      3'd4: bar_colour = 12'hF0F;
      3'd5: bar_colour = 12'hF00;
      3'd6: bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  end

  assign pixel_word = test_mode ? bar_colour : camera_word;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pixel_word       = camera_word;
`endif

  always_ff @(posedge PCLK) begin
    if (rst) begin
      hi_reg         <= 7'h00;
      byte_phase_reg <= 1'b0;
      addr_reg       <= '0;
      dout_reg       <= 12'h000;
      we_reg         <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      if (take_byte && !phase_now) hi_reg <= {d_s1_reg[7:4], d_s1_reg[2:0]};

      if (vsync_fall) begin
        addr_reg       <= '0;
        overflow_reg   <= 1'b0;
        byte_phase_reg <= 1'b0;
      end else begin
        if (take_byte)                  byte_phase_reg <= ~phase_now;
        else if (href_rise | href_fall) byte_phase_reg <= 1'b0;  // drops an odd trailing byte

        // Address advances the cycle after its write; pixels are at least
        // two cycles apart, so it is always current before the next write.
        if (we_reg) addr_reg <= addr_reg + ADDR_W'(1);

        if (pixel_done) begin
          if (frame_full) begin
            overflow_reg <= 1'b1;
          end else begin
            we_reg   <= 1'b1;
            dout_reg <= pixel_word;
          end
        end
      end
    end
  end

  assign addr     = addr_reg;
  assign dout     = dout_reg;
  assign we       = we_reg;
  assign overflow = overflow_reg;

endmodule
